editor_campos_rtc: RTL and testbench

//  Next-generation field editor for the RTC programming path. Loads one BCD field (time, date or timer)

---
 rtl/rtc_campos_pkg.sv | 104 ++++++++++
 rtl/boton_autorepeat.sv | 93 +++++++++
 rtl/editor_campos_rtc.sv | 165 ++++++++++++++++
 tb/tb_editor_campos_rtc.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_campos_pkg.sv
// ---------------------------------------------------------------------------
// rtc_campos_pkg
// Shared definitions for the RTC field editor:
//   - field index constants and per-field min/max tables
//   - autorepeat state encoding
//   - BCD <-> binary helpers, calendar day limit, 12h output formatting
// ---------------------------------------------------------------------------
package rtc_campos_pkg;

    localparam int F_SEG    = 0;
    localparam int F_MIN    = 1;
    localparam int F_HORA   = 2;
    localparam int F_DAY    = 3;
    localparam int F_MONTH  = 4;
    localparam int F_YEAR   = 5;
    localparam int F_SEG_T  = 6;
    localparam int F_MIN_T  = 7;
    localparam int F_HORA_T = 8;
    localparam int N_TABLE  = 9;

    // Timer fields share the limits of their clock counterparts.
    // The day maximum here is only a fallback; the real one comes from the calendar.
    localparam logic [6:0] FIELD_MIN [N_TABLE] = '{
        F_SEG: 7'd0, F_MIN: 7'd0, F_HORA: 7'd0, F_DAY: 7'd1, F_MONTH: 7'd1,
        F_YEAR: 7'd0, F_SEG_T: 7'd0, F_MIN_T: 7'd0, F_HORA_T: 7'd0
    };
    localparam logic [6:0] FIELD_MAX [N_TABLE] = '{
        F_SEG: 7'd59, F_MIN: 7'd59, F_HORA: 7'd23, F_DAY: 7'd31, F_MONTH: 7'd12,
        F_YEAR: 7'd99, F_SEG_T: 7'd59, F_MIN_T: 7'd59, F_HORA_T: 7'd23
    };

    typedef enum logic [1:0] {
        AR_IDLE,
        AR_HOLD,
        AR_REPEAT
    } ar_state_t;

    // 8-bit result so malformed BCD (tens digit above 9) still converts
    // without wrapping; the caller clamps it into range afterwards.
    function automatic logic [7:0] bcd2bin(input logic [7:0] bcd);
        return ({4'b0000, bcd[7:4]} * 8'd10) + {4'b0000, bcd[3:0]};
    endfunction

    function automatic logic [7:0] bin2bcd(input logic [6:0] bin);
        return {4'(bin / 7'd10), 4'(bin % 7'd10)};
    endfunction

    function automatic logic [6:0] days_in_month(input logic [7:0] month_bcd,
                                                 input logic [7:0] year_bcd);
        logic [6:0] days;
        logic       leap;
        leap = ((bcd2bin(year_bcd) % 8'd4) == 8'd0);
        case (month_bcd)
            8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: days = 7'd31;
            8'h04, 8'h06, 8'h09, 8'h11:                      days = 7'd30;
            8'h02:                                           days = leap ? 7'd29 : 7'd28;
            default:                                         days = 7'd31;
        endcase
        return days;
    endfunction

    function automatic logic is_hour_field(input int idx);
        return (idx == F_HORA) || (idx == F_HORA_T);
    endfunction

    function automatic logic [6:0] field_lo(input int idx, input logic h12);
        logic [6:0] lo;
        lo = 7'd0;
        if (idx >= 0 && idx < N_TABLE) begin
            lo = FIELD_MIN[idx[3:0]];
        end
        if (h12) begin
            lo = 7'd1;
        end
        return lo;
    endfunction

    // Fields beyond the table behave as plain 0..99 counters.
    function automatic logic [6:0] field_hi(input int idx, input logic h12,
                                            input logic [6:0] dim);
        logic [6:0] hi;
        hi = 7'd99;
        if (idx >= 0 && idx < N_TABLE) begin
            hi = FIELD_MAX[idx[3:0]];
        end
        if (h12) begin
            hi = 7'd12;
        end
        if (idx == F_DAY) begin
            hi = dim;
        end
        return hi;
    endfunction

    // 12h hours carry the 12h flag in bit 6 and PM in bit 5; the tens
    // digit of 1..12 never exceeds 1, so only one bit of it is kept.
    function automatic logic [7:0] fmt_bcd(input logic [6:0] bin, input logic pm,
                                           input logic h12);
        logic [7:0] b;
        b = bin2bcd(bin);
        return h12 ? {2'b01, pm, b[4], b[3:0]} : b;
    endfunction

endpackage

// File: rtl/boton_autorepeat.sv
// ---------------------------------------------------------------------------
// boton_autorepeat
// Turns one debounced pushbutton level into step pulses: one on the press,
// another after HOLD_CYC cycles of holding, then one every REPEAT_CYC cycles.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous active-high reset
//   pb      in  button level (debounced, synchronous)
//   inhibit in  other button is pressed; cancels stepping
//   step    out one-cycle step request (combinational)
// ---------------------------------------------------------------------------
module boton_autorepeat
    import rtc_campos_pkg::*;
#(
    parameter int HOLD_CYC   = 50000000,
    parameter int REPEAT_CYC = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic pb,
    input  logic inhibit,
    output logic step
);

    localparam int MAX_CYC = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ar_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pb_q;

    // pb_q also loads during reset so a button held through reset looks
    // already-pressed and cannot fire until it is released and pressed again.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= AR_IDLE;
            cnt   <= '0;
            pb_q  <= pb;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pb_q  <= pb;
        end
    end

    // Counter holds the number of cycles since the last step, so a step fires
    // exactly HOLD_CYC (then REPEAT_CYC) cycles after the previous one. Inhibit
    // drops back to idle; the still-high pb_q then requires a fresh press.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        step    = 1'b0;
        if (!pb || inhibit) begin
            state_n = AR_IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                AR_IDLE: begin
                    if (!pb_q) begin
                        step    = 1'b1;
                        state_n = AR_HOLD;
                        cnt_n   = CNT_ONE;
                    end
                end
                AR_HOLD: begin
                    if (cnt == HOLD_LIM) begin
                        step    = 1'b1;
                        state_n = AR_REPEAT;
                        cnt_n   = CNT_ONE;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
                AR_REPEAT: begin
                    if (cnt == REP_LIM) begin
                        step  = 1'b1;
                        cnt_n = CNT_ONE;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_n = AR_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/editor_campos_rtc.sv
// ---------------------------------------------------------------------------
// editor_campos_rtc
// Loads one BCD field of the RTC, steps it up/down from the pushbuttons with
// wrap-around, per-field limits, calendar day limit and 12h/PM handling, and
// presents the edited value in BCD with a write strobe.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   Num_Ld            one-cycle load request for field sel_LD
//   PB_up, PB_down    step buttons (levels)
//   SF_24_12          hour format: 0 = 24h, 1 = 12h
//   sel_LD            field index to load
//   fields_in         packed BCD fields, field k at [8k+7:8k]
//   Wr_BCD            edited value in BCD
//   wr_stb            one-cycle pulse on every step
//   field_act         index of the field being edited
// ---------------------------------------------------------------------------
module editor_campos_rtc
    import rtc_campos_pkg::*;
#(
    parameter int N_FIELDS   = 9,
    parameter int SEL_W      = 4,
    parameter int HOLD_CYC   = 50000000,
    parameter int REPEAT_CYC = 10000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Num_Ld,
    input  logic                  PB_up,
    input  logic                  PB_down,
    input  logic                  SF_24_12,
    input  logic [SEL_W-1:0]      sel_LD,
    input  logic [8*N_FIELDS-1:0] fields_in,
    output logic [7:0]            Wr_BCD,
    output logic                  wr_stb,
    output logic [SEL_W-1:0]      field_act
);

    localparam logic [SEL_W:0] N_F = (SEL_W + 1)'(N_FIELDS);

    logic [7:0]       field_arr [N_FIELDS];
    logic             step_up, step_down;
    logic             in_range, ld_valid;
    logic [SEL_W-1:0] ld_idx;
    logic [7:0]       ld_field;
    logic [6:0]       dim;

    logic [6:0]       value, value_n;
    logic             pm, pm_n;
    logic [SEL_W-1:0] act_n;
    logic [7:0]       wr_n;
    logic             stb_n;

    int               ld_int, cur_int;
    logic             ld_h12, cur_h12;
    logic [6:0]       ld_lo, ld_hi, cur_lo, cur_hi;
    logic [7:0]       ld_raw;

    for (genvar k = 0; k < N_FIELDS; k++) begin : g_fields
        assign field_arr[k] = fields_in[8*k +: 8];
    end

    boton_autorepeat #(
        .HOLD_CYC   (HOLD_CYC),
        .REPEAT_CYC (REPEAT_CYC)
    ) u_ar_up (
        .clk     (clk),
        .reset   (reset),
        .pb      (PB_up),
        .inhibit (PB_down),
        .step    (step_up)
    );

    boton_autorepeat #(
        .HOLD_CYC   (HOLD_CYC),
        .REPEAT_CYC (REPEAT_CYC)
    ) u_ar_down (
        .clk     (clk),
        .reset   (reset),
        .pb      (PB_down),
        .inhibit (PB_up),
        .step    (step_down)
    );

    // Out-of-range selectors are steered to field 0 so the array read stays
    // in bounds; ld_valid keeps such a load from taking effect.
    assign in_range = ({1'b0, sel_LD} < N_F);
    assign ld_valid = Num_Ld && in_range;
    assign ld_idx   = in_range ? sel_LD : '0;
    assign ld_field = field_arr[ld_idx];
    assign dim      = days_in_month(field_arr[F_MONTH], field_arr[F_YEAR]);

    // Next-state datapath. Load wins over a step; a value that ended up
    // beyond the current maximum (e.g. day 31 after switching to April)
    // wraps to the minimum going up and lands on the maximum going down.
    always_comb begin
        ld_int  = int'(ld_idx);
        cur_int = int'(field_act);
        ld_h12  = is_hour_field(ld_int) && SF_24_12;
        cur_h12 = is_hour_field(cur_int) && SF_24_12;
        ld_lo   = field_lo(ld_int, ld_h12);
        ld_hi   = field_hi(ld_int, ld_h12, dim);
        cur_lo  = field_lo(cur_int, cur_h12);
        cur_hi  = field_hi(cur_int, cur_h12, dim);
        ld_raw  = ld_h12 ? bcd2bin({3'b000, ld_field[4:0]}) : bcd2bin(ld_field);

        value_n = value;
        pm_n    = pm;
        act_n   = field_act;
        wr_n    = Wr_BCD;
        stb_n   = 1'b0;

        if (ld_valid) begin
            if (ld_raw < {1'b0, ld_lo}) begin
                value_n = ld_lo;
            end else if (ld_raw > {1'b0, ld_hi}) begin
                value_n = ld_hi;
            end else begin
                value_n = ld_raw[6:0];
            end
            pm_n  = ld_h12 ? ld_field[5] : 1'b0;
            act_n = ld_idx;
            wr_n  = fmt_bcd(value_n, pm_n, ld_h12);
        end else if (step_up) begin
            if (value >= cur_hi) begin
                value_n = cur_lo;
            end else begin
                value_n = value + 7'd1;
            end
            if (cur_h12 && value == 7'd11) begin
                pm_n = ~pm;
            end
            wr_n  = fmt_bcd(value_n, pm_n, cur_h12);
            stb_n = 1'b1;
        end else if (step_down) begin
            if (value <= cur_lo || value > cur_hi) begin
                value_n = cur_hi;
            end else begin
                value_n = value - 7'd1;
            end
            if (cur_h12 && value == 7'd12) begin
                pm_n = ~pm;
            end
            wr_n  = fmt_bcd(value_n, pm_n, cur_h12);
            stb_n = 1'b1;
        end
    end

    // Edit register, active field and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            value     <= 7'd0;
            pm        <= 1'b0;
            field_act <= '0;
            Wr_BCD    <= 8'h00;
            wr_stb    <= 1'b0;
        end else begin
            value     <= value_n;
            pm        <= pm_n;
            field_act <= act_n;
            Wr_BCD    <= wr_n;
            wr_stb    <= stb_n;
        end
    end

endmodule

// File: tb/tb_editor_campos_rtc.sv
// ---------------------------------------------------------------------------
// tb_editor_campos_rtc
// Directed vector table for load/step/limit/12h behaviour, plus hand-written
// sequences for hold-to-repeat and reset while a button is held.
// ---------------------------------------------------------------------------
module tb_editor_campos_rtc;

    localparam int N_FIELDS = 9;
    localparam int SEL_W    = 4;
    localparam int HOLD     = 8;
    localparam int REP      = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  Num_Ld;
    logic                  PB_up;
    logic                  PB_down;
    logic                  SF_24_12;
    logic [SEL_W-1:0]      sel_LD;
    logic [8*N_FIELDS-1:0] fields_in;
    logic [7:0]            Wr_BCD;
    logic                  wr_stb;
    logic [SEL_W-1:0]      field_act;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic                  ld;
        logic                  up;
        logic                  dn;
        logic                  sf;
        logic [SEL_W-1:0]      sel;
        logic [8*N_FIELDS-1:0] flds;
        logic [7:0]            exp_wr;
        logic                  exp_stb;
        logic [SEL_W-1:0]      exp_act;
    } vec_t;

    vec_t vecs [64];
    int   n_vec = 0;

    editor_campos_rtc #(
        .N_FIELDS   (N_FIELDS),
        .SEL_W      (SEL_W),
        .HOLD_CYC   (HOLD),
        .REPEAT_CYC (REP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Num_Ld    (Num_Ld),
        .PB_up     (PB_up),
        .PB_down   (PB_down),
        .SF_24_12  (SF_24_12),
        .sel_LD    (sel_LD),
        .fields_in (fields_in),
        .Wr_BCD    (Wr_BCD),
        .wr_stb    (wr_stb),
        .field_act (field_act)
    );

    always #5 clk = ~clk;

    function automatic logic [8*N_FIELDS-1:0] mk_fields(
        input logic [7:0] seg, input logic [7:0] mn, input logic [7:0] hr,
        input logic [7:0] dy, input logic [7:0] mo, input logic [7:0] yr,
        input logic [7:0] st, input logic [7:0] mt, input logic [7:0] ht);
        return {ht, mt, st, yr, mo, dy, hr, mn, seg};
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    task automatic addVec(input logic ld, input logic up, input logic dn, input logic sf,
                          input logic [SEL_W-1:0] sel, input logic [8*N_FIELDS-1:0] flds,
                          input logic [7:0] exp_wr, input logic exp_stb,
                          input logic [SEL_W-1:0] exp_act);
        vecs[n_vec].ld      = ld;
        vecs[n_vec].up      = up;
        vecs[n_vec].dn      = dn;
        vecs[n_vec].sf      = sf;
        vecs[n_vec].sel     = sel;
        vecs[n_vec].flds    = flds;
        vecs[n_vec].exp_wr  = exp_wr;
        vecs[n_vec].exp_stb = exp_stb;
        vecs[n_vec].exp_act = exp_act;
        n_vec++;
    endtask

    task automatic applyStimulus(input logic ld, input logic up, input logic dn,
                                 input logic sf, input logic [SEL_W-1:0] sel,
                                 input logic [8*N_FIELDS-1:0] flds);
        Num_Ld    = ld;
        PB_up     = up;
        PB_down   = dn;
        SF_24_12  = sf;
        sel_LD    = sel;
        fields_in = flds;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp_wr,
                               input logic exp_stb, input logic [SEL_W-1:0] exp_act);
        checks++;
        if (Wr_BCD !== exp_wr) begin
            errors++;
            $display("[TB] FAIL %s Wr_BCD: got %h, expected %h", name, Wr_BCD, exp_wr);
        end
        checks++;
        if (wr_stb !== exp_stb) begin
            errors++;
            $display("[TB] FAIL %s wr_stb: got %b, expected %b", name, wr_stb, exp_stb);
        end
        checks++;
        if (field_act !== exp_act) begin
            errors++;
            $display("[TB] FAIL %s field_act: got %0d, expected %0d", name, field_act, exp_act);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [8*N_FIELDS-1:0] f1, f2, f3;
        int steps;
        logic stb_exp;

        f1 = mk_fields(8'h00, 8'h59, 8'h71, 8'h28, 8'h02, 8'h24, 8'h30, 8'h00, 8'h23);
        f2 = mk_fields(8'h00, 8'h59, 8'h71, 8'h28, 8'h02, 8'h23, 8'h30, 8'h00, 8'h23);
        f3 = mk_fields(8'h00, 8'h59, 8'h71, 8'h31, 8'h04, 8'h23, 8'h30, 8'h00, 8'h23);

        // minutes wrap both ways
        addVec(1, 0, 0, 0, 4'd1, f1, 8'h59, 0, 4'd1);
        addVec(0, 0, 0, 0, 4'd1, f1, 8'h59, 0, 4'd1);
        addVec(0, 1, 0, 0, 4'd1, f1, 8'h00, 1, 4'd1);
        addVec(0, 0, 0, 0, 4'd1, f1, 8'h00, 0, 4'd1);
        addVec(0, 0, 1, 0, 4'd1, f1, 8'h59, 1, 4'd1);
        addVec(0, 0, 0, 0, 4'd1, f1, 8'h59, 0, 4'd1);
        // February in a leap year, then in a common year
        addVec(1, 0, 0, 0, 4'd3, f1, 8'h28, 0, 4'd3);
        addVec(0, 1, 0, 0, 4'd3, f1, 8'h29, 1, 4'd3);
        addVec(0, 0, 0, 0, 4'd3, f1, 8'h29, 0, 4'd3);
        addVec(0, 1, 0, 0, 4'd3, f1, 8'h01, 1, 4'd3);
        addVec(0, 0, 0, 0, 4'd3, f1, 8'h01, 0, 4'd3);
        addVec(1, 0, 0, 0, 4'd3, f2, 8'h28, 0, 4'd3);
        addVec(0, 1, 0, 0, 4'd3, f2, 8'h01, 1, 4'd3);
        addVec(0, 0, 0, 0, 4'd3, f2, 8'h01, 0, 4'd3);
        // April: day 31 clamps to 30 on load, 30 wraps to 01
        addVec(1, 0, 0, 0, 4'd3, f3, 8'h30, 0, 4'd3);
        addVec(0, 1, 0, 0, 4'd3, f3, 8'h01, 1, 4'd3);
        addVec(0, 0, 0, 0, 4'd3, f3, 8'h01, 0, 4'd3);
        // 12h hour: 11 PM -> 12 AM -> 1 AM -> 12 AM -> 11 PM
        addVec(1, 0, 0, 1, 4'd2, f1, 8'h71, 0, 4'd2);
        addVec(0, 1, 0, 1, 4'd2, f1, 8'h52, 1, 4'd2);
        addVec(0, 0, 0, 1, 4'd2, f1, 8'h52, 0, 4'd2);
        addVec(0, 1, 0, 1, 4'd2, f1, 8'h41, 1, 4'd2);
        addVec(0, 0, 0, 1, 4'd2, f1, 8'h41, 0, 4'd2);
        addVec(0, 0, 1, 1, 4'd2, f1, 8'h52, 1, 4'd2);
        addVec(0, 0, 0, 1, 4'd2, f1, 8'h52, 0, 4'd2);
        addVec(0, 0, 1, 1, 4'd2, f1, 8'h71, 1, 4'd2);
        addVec(0, 0, 0, 1, 4'd2, f1, 8'h71, 0, 4'd2);
        // 24h timer hour wraps 23 <-> 00
        addVec(1, 0, 0, 0, 4'd8, f1, 8'h23, 0, 4'd8);
        addVec(0, 1, 0, 0, 4'd8, f1, 8'h00, 1, 4'd8);
        addVec(0, 0, 0, 0, 4'd8, f1, 8'h00, 0, 4'd8);
        addVec(0, 0, 1, 0, 4'd8, f1, 8'h23, 1, 4'd8);
        addVec(0, 0, 0, 0, 4'd8, f1, 8'h23, 0, 4'd8);
        // load together with a press: load wins, no strobe
        addVec(1, 1, 0, 0, 4'd0, f1, 8'h00, 0, 4'd0);
        addVec(0, 1, 0, 0, 4'd0, f1, 8'h00, 0, 4'd0);
        addVec(0, 0, 0, 0, 4'd0, f1, 8'h00, 0, 4'd0);
        // both buttons, then the held one alone: nothing until a fresh press
        addVec(0, 1, 1, 0, 4'd0, f1, 8'h00, 0, 4'd0);
        addVec(0, 1, 0, 0, 4'd0, f1, 8'h00, 0, 4'd0);
        addVec(0, 0, 0, 0, 4'd0, f1, 8'h00, 0, 4'd0);
        addVec(0, 1, 0, 0, 4'd0, f1, 8'h01, 1, 4'd0);
        addVec(0, 0, 0, 0, 4'd0, f1, 8'h01, 0, 4'd0);
        // out-of-range selector ignored
        addVec(1, 0, 0, 0, 4'd12, f1, 8'h01, 0, 4'd0);
        addVec(0, 0, 0, 0, 4'd12, f1, 8'h01, 0, 4'd0);

        reset     = 1'b1;
        Num_Ld    = 1'b0;
        PB_up     = 1'b0;
        PB_down   = 1'b0;
        SF_24_12  = 1'b0;
        sel_LD    = '0;
        fields_in = f1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 8'h00, 1'b0, 4'd0);
        reset = 1'b0;

        for (int i = 0; i < n_vec; i++) begin
            applyStimulus(vecs[i].ld, vecs[i].up, vecs[i].dn, vecs[i].sf, vecs[i].sel,
                          vecs[i].flds);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_wr, vecs[i].exp_stb,
                        vecs[i].exp_act);
        end

        // Hold-to-repeat on seconds: steps at press, after HOLD, then every REP
        applyStimulus(1, 0, 0, 0, 4'd0, f1);
        checkOutput("hold_load", 8'h00, 1'b0, 4'd0);
        steps = 0;
        for (int k = 0; k < 20; k++) begin
            stb_exp = (k == 0) || (k == HOLD) || (k > HOLD && ((k - HOLD) % REP) == 0);
            if (stb_exp) steps++;
            applyStimulus(0, 1, 0, 0, 4'd0, f1);
            checkOutput($sformatf("hold_c%0d", k), to_bcd(steps), stb_exp, 4'd0);
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 0, 0, 4'd0, f1);
            checkOutput($sformatf("release_c%0d", k), 8'h05, 1'b0, 4'd0);
        end

        // Reset while a button is held
        applyStimulus(0, 1, 0, 0, 4'd0, f1);
        checkOutput("pre_rst_press", 8'h06, 1'b1, 4'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 0, 0, 4'd0, f1);
            checkOutput($sformatf("pre_rst_hold%0d", k), 8'h06, 1'b0, 4'd0);
        end
        reset = 1'b1;
        applyStimulus(0, 1, 0, 0, 4'd0, f1);
        checkOutput("rst_held", 8'h00, 1'b0, 4'd0);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(0, 1, 0, 0, 4'd0, f1);
            checkOutput($sformatf("post_rst_hold%0d", k), 8'h00, 1'b0, 4'd0);
        end
        applyStimulus(0, 0, 0, 0, 4'd0, f1);
        checkOutput("post_rst_release", 8'h00, 1'b0, 4'd0);
        applyStimulus(0, 1, 0, 0, 4'd0, f1);
        checkOutput("post_rst_press", 8'h01, 1'b1, 4'd0);
        applyStimulus(0, 0, 0, 0, 4'd0, f1);
        checkOutput("post_rst_idle", 8'h01, 1'b0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
